// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared fetch/decode pipeline constants
package if_id_stage_pkg;

   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Redirect targets are always word aligned.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_stage_pc_register.sv
// rtl/if_id_stage_pc_register.sv - program counter with next-PC priority mux
module pc_register
   import if_id_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_write,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              redirect
);

   logic [ADDR_W-1:0] pc_next;

   // A redirect belongs to an older instruction, so it wins over a stall.
   always_comb begin
      pc_next  = pc;
      redirect = branch_taken | jump;
      pc_plus4 = pc + 32'd4;
      if (branch_taken) begin
         pc_next = word_align(branch_target);
      end else if (jump) begin
         pc_next = word_align(jump_target);
      end else if (pc_write) begin
         pc_next = pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch stage with IF/ID register and stall counter
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCWrite,
   input  logic              IF_ID_write,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [31:0]       imem_instr,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       IF_ID_instr,
   output logic [ADDR_W-1:0] IF_ID_pc4,
   output logic              IF_ID_valid,
   output logic [CNT_W-1:0]  stall_count
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              redirect;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk           (clk),
      .reset         (reset),
      .pc_write      (PCWrite),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .redirect      (redirect)
   );

   assign imem_addr = pc;

   // Flush on redirect: the fetched instruction is on the wrong path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IF_ID_instr <= NOP_INSTR;
         IF_ID_pc4   <= '0;
         IF_ID_valid <= 1'b0;
      end else if (redirect) begin
         IF_ID_instr <= NOP_INSTR;
         IF_ID_pc4   <= '0;
         IF_ID_valid <= 1'b0;
      end else if (IF_ID_write) begin
         IF_ID_instr <= imem_instr;
         IF_ID_pc4   <= pc_plus4;
         IF_ID_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (!PCWrite && !redirect && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized self-checking bench for if_id_stage
module tb_if_id_stage;

   localparam int          CNT_W    = 4;
   localparam logic [31:0] TB_RESET = 32'h0000_0000;
   localparam int          SAT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             PCWrite, IF_ID_write, branch_taken, jump;
   logic [31:0]      branch_target, jump_target, imem_instr;
   logic [31:0]      imem_addr, IF_ID_instr, IF_ID_pc4;
   logic             IF_ID_valid;
   logic [CNT_W-1:0] stall_count;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          m_stall;

   if_id_stage #(.RESET_PC(TB_RESET), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .PCWrite       (PCWrite),
      .IF_ID_write   (IF_ID_write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_instr    (imem_instr),
      .imem_addr     (imem_addr),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_pc4     (IF_ID_pc4),
      .IF_ID_valid   (IF_ID_valid),
      .stall_count   (stall_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {addr[15:0], ~addr[17:2]} ^ 32'h5A3C_0F96;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".imem_addr"}, imem_addr, m_pc);
      check_val({tag, ".instr"}, IF_ID_instr, m_instr);
      check_val({tag, ".pc4"}, IF_ID_pc4, m_pc4);
      check_val({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, m_valid});
      check_val({tag, ".stall"}, {28'd0, stall_count}, m_stall);
   endtask

   task automatic model_reset();
      m_pc = TB_RESET; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_stall = 0;
   endtask

   // One clock edge: drive inputs, advance the reference model, then compare.
   task automatic step(input string tag, input logic pcw, input logic ifw,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
      logic [31:0] fetched;
      PCWrite = pcw; IF_ID_write = ifw;
      branch_taken = br; branch_target = bt;
      jump = jp; jump_target = jt;
      fetched = mem_word(m_pc);
      imem_instr = fetched;
      @(posedge clk);
      if (br || jp) begin
         m_pc = br ? (bt & ~32'd3) : (jt & ~32'd3);
         m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      end else begin
         if (ifw) begin
            m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
         end
         if (pcw) m_pc = m_pc + 32'd4;
         else if (m_stall < SAT_MAX) m_stall++;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b1;
      PCWrite = 1'b0; IF_ID_write = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_target = 32'd0; jump_target = 32'd0; imem_instr = 32'd0;
      model_reset();
      #23;
      check_all("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 4; i++) step("advance", 1, 1, 0, 0, 0, 0);
      step("stall1", 0, 0, 0, 0, 0, 0);
      step("stall2", 0, 0, 0, 0, 0, 0);
      check_val("stall_eq2", {28'd0, stall_count}, 32'd2);
      step("jump20", 1, 1, 0, 0, 1, 32'h20);
      step("br_over_stall", 0, 0, 1, 32'h103, 0, 0);
      check_val("br_pc100", imem_addr, 32'h100);
      step("br_and_jump", 1, 1, 1, 32'h200, 1, 32'h300);
      check_val("br_wins", imem_addr, 32'h200);
      step("jump_top", 1, 1, 0, 0, 1, 32'hFFFF_FFFE);
      step("wrap", 1, 1, 0, 0, 0, 0);
      check_val("wrap_pc0", imem_addr, 32'h0);
      for (int i = 0; i < 20; i++) step("saturate", 0, $urandom_range(0, 1), 0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 9);
         step("random", r > 2, $urandom_range(0, 3) != 0,
              r == 0, $urandom(), (r == 1) || ($urandom_range(0, 15) == 0), $urandom());
      end

      // Reset mid-stall and mid-redirect, asynchronously between edges.
      for (int k = 0; k < 2; k++) begin
         reset = 1'b1; #2;
         model_reset();
         @(posedge clk); #1;
         reset = 1'b0;
         for (int i = 0; i < 5; i++) step("prestall", 0, 1, 0, 0, 0, 0);
         check_val("stall_eq5", {28'd0, stall_count}, 32'd5);
         PCWrite = 1'b0;
         branch_taken = (k == 1); branch_target = 32'h0000_4440;
         #2;
         reset = 1'b1;
         model_reset();
         #1;
         check_all("async_reset");
         @(posedge clk); #1;
         check_all("held_reset");
         reset = 1'b0;
         check_all("post_release");
         step("first_fetch", 1, 1, 0, 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
